// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and bus event types shared by the I2C target and initiator drivers.
package i2c_pkg;
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_DEV_ADDR = 4'd1;
   localparam logic [3:0] ST_DEV_ACK  = 4'd2;
   localparam logic [3:0] ST_POINTER  = 4'd3;
   localparam logic [3:0] ST_PTR_ACK  = 4'd4;
   localparam logic [3:0] ST_WR_BYTE  = 4'd5;
   localparam logic [3:0] ST_WR_ACK   = 4'd6;
   localparam logic [3:0] ST_RD_BYTE  = 4'd7;
   localparam logic [3:0] ST_RD_ACK   = 4'd8;
   localparam logic [3:0] ST_IGNORE   = 4'd9;

   typedef enum logic [2:0] {EV_NONE, EV_START, EV_STOP, EV_RISE, EV_FALL} i2c_event_e;

   // START/STOP outrank SCL edges when both are seen in one cycle
   function automatic i2c_event_e bus_event(input logic scl_q, input logic scl,
                                            input logic sda_q, input logic sda);
      return (scl_q & scl & sda_q & ~sda) ? EV_START :
             (scl_q & scl & ~sda_q & sda) ? EV_STOP  :
             (~scl_q & scl)               ? EV_RISE  :
             (scl_q & ~scl)               ? EV_FALL  : EV_NONE;
   endfunction
endpackage

// File: rtl/i2c_filter.sv
// i2c_filter: 2-flop synchroniser followed by a FilterLength-sample glitch filter.
module i2c_filter #(
   parameter int FilterLength = 3
) (
   input  logic ipClk,
   input  logic ipReset,
   input  logic ipIn,
   output logic opOut
);
   logic [1:0]              r_sync;
   logic [FilterLength-1:0] r_hist;
   logic                    r_out;

   always_ff @(posedge ipClk or negedge ipReset)
      if (!ipReset) begin
         r_sync <= '1;
         r_hist <= '1;
         r_out  <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], ipIn};
         r_hist <= (r_hist << 1) | FilterLength'(r_sync[1]);
         r_out  <= (&r_hist) ? 1'b1 : (~|r_hist) ? 1'b0 : r_out;
      end

   assign opOut = r_out;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C register-file target with auto-incrementing pointer, no clock stretching.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] Address      = 7'h48,
   parameter int         FilterLength = 3
) (
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic       ipI2C_SClk,
   output logic       opI2C_SClk,
   input  logic       ipI2C_Data,
   output logic       opI2C_Data,
   output logic [7:0] opAddress,
   output logic [7:0] opWrData,
   output logic       opWrEnable,
   output logic       opRdEnable,
   input  logic [7:0] ipRdData,
   output logic       opBusy
);
   logic       w_scl, w_sda, w_rx, w_full, w_match;
   i2c_event_e w_ev;
   logic       r_scl_q, r_sda_q;
   logic [3:0] r_state, r_cnt;
   logic [7:0] r_shift, r_addr, r_wdata;
   logic       r_sda_o, r_wr_en, r_rd_en, r_rd_ld, r_rw, r_busy;

   i2c_filter #(.FilterLength(FilterLength)) u_scl (
      .ipClk(ipClk), .ipReset(ipReset), .ipIn(ipI2C_SClk), .opOut(w_scl));
   i2c_filter #(.FilterLength(FilterLength)) u_sda (
      .ipClk(ipClk), .ipReset(ipReset), .ipIn(ipI2C_Data), .opOut(w_sda));

   assign w_ev    = bus_event(r_scl_q, w_scl, r_sda_q, w_sda);
   assign w_rx    = (r_state == ST_DEV_ADDR) || (r_state == ST_POINTER) || (r_state == ST_WR_BYTE);
   assign w_full  = r_cnt == 4'd8;
   assign w_match = r_shift[7:1] == Address;

   always_ff @(posedge ipClk or negedge ipReset)
      if (!ipReset) begin
         r_scl_q <= 1'b1;
         r_sda_q <= 1'b1;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '1;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sda_o <= 1'b1;
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         r_rd_ld <= 1'b0;
         r_rw    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_scl_q <= w_scl;
         r_sda_q <= w_sda;
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         r_rd_ld <= r_rd_en;
         if (r_rd_ld) r_shift <= ipRdData;
         if (r_wr_en) r_addr <= r_addr + 8'd1;
         if (w_ev == EV_START) begin
            r_state <= ST_DEV_ADDR;
            r_cnt   <= '0;
            r_sda_o <= 1'b1;
         end else if (w_ev == EV_STOP) begin
            r_state <= ST_IDLE;
            r_sda_o <= 1'b1;
            r_busy  <= 1'b0;
         end else if (w_ev == EV_RISE) begin
            if (w_rx) r_shift <= {r_shift[6:0], w_sda};
            if (w_rx || r_state == ST_RD_BYTE) r_cnt <= r_cnt + 4'd1;
            // read data is fetched during the ACK high phase so the MSB is ready at the falling edge
            if (r_state == ST_DEV_ACK && r_rw) r_rd_en <= 1'b1;
            if (r_state == ST_RD_ACK) begin
               if (w_sda) r_state <= ST_IGNORE;
               else begin
                  r_addr  <= r_addr + 8'd1;
                  r_rd_en <= 1'b1;
               end
            end
         end else if (w_ev == EV_FALL) begin
            case (r_state)
               ST_DEV_ADDR: if (w_full) begin
                  r_state <= w_match ? ST_DEV_ACK : ST_IGNORE;
                  r_sda_o <= !w_match;
                  r_busy  <= r_busy | w_match;
                  r_rw    <= r_shift[0];
               end
               ST_DEV_ACK: begin
                  r_state <= r_rw ? ST_RD_BYTE : ST_POINTER;
                  r_sda_o <= r_rw ? r_shift[7] : 1'b1;
                  r_cnt   <= '0;
               end
               ST_POINTER: if (w_full) begin
                  r_state <= ST_PTR_ACK;
                  r_sda_o <= 1'b0;
                  r_addr  <= r_shift;
               end
               ST_PTR_ACK: begin
                  r_state <= ST_WR_BYTE;
                  r_sda_o <= 1'b1;
                  r_cnt   <= '0;
               end
               ST_WR_BYTE: if (w_full) begin
                  r_state <= ST_WR_ACK;
                  r_sda_o <= 1'b0;
                  r_wdata <= r_shift;
               end
               ST_WR_ACK: begin
                  r_state <= ST_WR_BYTE;
                  r_sda_o <= 1'b1;
                  r_cnt   <= '0;
                  r_wr_en <= 1'b1;
               end
               ST_RD_BYTE: if (w_full) begin
                  r_state <= ST_RD_ACK;
                  r_sda_o <= 1'b1;
               end else begin
                  r_sda_o <= r_shift[6];
                  r_shift <= {r_shift[6:0], 1'b1};
               end
               ST_RD_ACK: begin
                  r_state <= ST_RD_BYTE;
                  r_sda_o <= r_shift[7];
                  r_cnt   <= '0;
               end
               default: ;
            endcase
         end
      end

   assign opI2C_SClk = 1'b1;
   assign opI2C_Data = r_sda_o;
   assign opAddress  = r_addr;
   assign opWrData   = r_wdata;
   assign opWrEnable = r_wr_en;
   assign opRdEnable = r_rd_en;
   assign opBusy     = r_busy;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C initiator with a strobe scoreboard for i2c_target.
module tb_i2c_target;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1, m_sda = 1'b1;
   logic       o_scl, o_sda;
   logic [7:0] o_addr, o_wdata, rd_data;
   logic       o_wr, o_rd, o_busy;
   logic [7:0] mem [256];
   int         n_tests = 0, n_fail = 0;
   logic       sda_low_seen = 1'b0;

   typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   wr_t        e_wr;
   logic [7:0] e_rd;

   always #5 clk = ~clk;

   i2c_target dut (
      .ipClk(clk), .ipReset(rst_n),
      .ipI2C_SClk(m_scl & o_scl), .opI2C_SClk(o_scl),
      .ipI2C_Data(m_sda & o_sda), .opI2C_Data(o_sda),
      .opAddress(o_addr), .opWrData(o_wdata), .opWrEnable(o_wr), .opRdEnable(o_rd),
      .ipRdData(rd_data), .opBusy(o_busy));

   always @(posedge clk) if (o_rd) rd_data <= mem[o_addr];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every strobe must match the next queued expectation
   always @(negedge clk) begin
      if (!o_sda) sda_low_seen = 1'b1;
      if (o_wr) begin
         if (exp_wr.size() == 0) check("unexpected_write", {o_addr, o_wdata}, 16'hxxxx);
         else begin
            e_wr = exp_wr.pop_front();
            check("write_strobe", {o_addr, o_wdata}, {e_wr.a, e_wr.d});
         end
      end
      if (o_rd) begin
         if (exp_rd.size() == 0) check("unexpected_read", {8'h00, o_addr}, 16'hxxxx);
         else begin
            e_rd = exp_rd.pop_front();
            check("read_strobe", {8'h00, o_addr}, {8'h00, e_rd});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      cyc(5);
      m_sda = b;
      if (glitch) begin
         cyc(2); m_scl = 1'b1; cyc(1); m_scl = 1'b0; cyc(2);
      end else cyc(5);
      m_scl = 1'b1;
      cyc(10);
      m_scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      cyc(5);
      m_sda = 1'b1;
      cyc(5);
      m_scl = 1'b1;
      cyc(5);
      b = m_sda & o_sda;
      cyc(5);
      m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] v);
      for (int i = 7; i >= 0; i--) read_bit(v[i]);
   endtask

   task automatic start();
      cyc(5); m_sda = 1'b1; cyc(5); m_scl = 1'b1; cyc(10);
      m_sda = 1'b0; cyc(10); m_scl = 1'b0;
   endtask

   task automatic stop();
      cyc(5); m_sda = 1'b0; cyc(5); m_scl = 1'b1; cyc(10);
      m_sda = 1'b1; cyc(10);
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic       ack;
      logic [7:0] v;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[255] = 8'h3C;
      mem[0]   = 8'hC3;
      cyc(4);
      check("rst_sda", {15'd0, o_sda}, 16'd1);
      check("rst_scl", {15'd0, o_scl}, 16'd1);
      check("rst_addr", {8'd0, o_addr}, 16'd0);
      check("rst_strobes", {14'd0, o_wr, o_rd}, 16'd0);
      check("rst_busy", {15'd0, o_busy}, 16'd0);
      rst_n = 1'b1;
      cyc(10);

      // two writes from pointer 0x10
      exp_wr.push_back({8'h10, 8'hAB});
      exp_wr.push_back({8'h11, 8'hCD});
      start();
      send_byte(8'h90, -1, ack); check("w_dev_ack", {15'd0, ack}, 16'd0);
      check("w_busy", {15'd0, o_busy}, 16'd1);
      send_byte(8'h10, -1, ack); check("w_ptr_ack", {15'd0, ack}, 16'd0);
      send_byte(8'hAB, -1, ack); check("w_d0_ack", {15'd0, ack}, 16'd0);
      send_byte(8'hCD, -1, ack); check("w_d1_ack", {15'd0, ack}, 16'd0);
      stop();
      check("w_addr", {8'd0, o_addr}, 16'h0012);
      check("w_busy_end", {15'd0, o_busy}, 16'd0);

      // pointer 0xFF, repeated START, two reads wrapping to 0x00
      exp_rd.push_back(8'hFF);
      exp_rd.push_back(8'h00);
      start();
      send_byte(8'h90, -1, ack); check("r_dev_ack", {15'd0, ack}, 16'd0);
      send_byte(8'hFF, -1, ack); check("r_ptr_ack", {15'd0, ack}, 16'd0);
      start();
      send_byte(8'h91, -1, ack); check("r_dev2_ack", {15'd0, ack}, 16'd0);
      read_byte(v); check("r_byte0", {8'd0, v}, 16'h003C);
      send_bit(1'b0, 1'b0);
      read_byte(v); check("r_byte1", {8'd0, v}, 16'h00C3);
      send_bit(1'b1, 1'b0);
      cyc(10);
      check("r_nack_release", {15'd0, o_sda}, 16'd1);
      stop();
      check("r_addr", {8'd0, o_addr}, 16'h0000);

      // foreign address is ignored entirely
      sda_low_seen = 1'b0;
      start();
      send_byte(8'hA0, -1, ack); check("n_dev_nack", {15'd0, ack}, 16'd1);
      check("n_busy", {15'd0, o_busy}, 16'd0);
      send_byte(8'h55, -1, ack); check("n_data_nack", {15'd0, ack}, 16'd1);
      stop();
      check("n_sda_never_low", {15'd0, sda_low_seen}, 16'd0);
      check("n_addr", {8'd0, o_addr}, 16'h0000);

      // STOP after 4 data bits discards the partial byte
      start();
      send_byte(8'h90, -1, ack); check("p_dev_ack", {15'd0, ack}, 16'd0);
      send_byte(8'h20, -1, ack); check("p_ptr_ack", {15'd0, ack}, 16'd0);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      stop();
      check("p_addr", {8'd0, o_addr}, 16'h0020);
      check("p_busy", {15'd0, o_busy}, 16'd0);
      check("p_sda", {15'd0, o_sda}, 16'd1);

      // one-sample SCL glitch inside a data byte
      exp_wr.push_back({8'h30, 8'hA5});
      start();
      send_byte(8'h90, -1, ack); check("g_dev_ack", {15'd0, ack}, 16'd0);
      send_byte(8'h30, -1, ack); check("g_ptr_ack", {15'd0, ack}, 16'd0);
      send_byte(8'hA5, 3, ack);  check("g_data_ack", {15'd0, ack}, 16'd0);
      stop();
      check("g_addr", {8'd0, o_addr}, 16'h0031);

      // reset while the target drives a low read bit
      exp_rd.push_back(8'h40);
      start();
      send_byte(8'h90, -1, ack); check("x_dev_ack", {15'd0, ack}, 16'd0);
      send_byte(8'h40, -1, ack); check("x_ptr_ack", {15'd0, ack}, 16'd0);
      start();
      send_byte(8'h91, -1, ack); check("x_dev2_ack", {15'd0, ack}, 16'd0);
      cyc(10);
      check("x_sda_driven", {15'd0, o_sda}, 16'd0);
      rst_n = 1'b0;
      #1;
      check("x_sda_released", {15'd0, o_sda}, 16'd1);
      check("x_strobes", {14'd0, o_wr, o_rd}, 16'd0);
      check("x_busy", {15'd0, o_busy}, 16'd0);
      check("x_addr", {8'd0, o_addr}, 16'h0000);
      cyc(3);
      m_scl = 1'b1;
      m_sda = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(10);
      exp_wr.push_back({8'h05, 8'h77});
      start();
      send_byte(8'h90, -1, ack); check("y_dev_ack", {15'd0, ack}, 16'd0);
      send_byte(8'h05, -1, ack); check("y_ptr_ack", {15'd0, ack}, 16'd0);
      send_byte(8'h77, -1, ack); check("y_data_ack", {15'd0, ack}, 16'd0);
      stop();
      check("y_addr", {8'd0, o_addr}, 16'h0006);

      cyc(10);
      check("wr_queue_empty", 16'(exp_wr.size()), 16'd0);
      check("rd_queue_empty", 16'(exp_rd.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter Address, default 7'h48, the 7-bit target address this block answers to.
REQ-002 SHALL have parameter FilterLength, default 3, the number of consecutive equal samples needed to accept an SCL/SDA level.
REQ-003 ipClk  in  1  system clock; all logic on its rising edge.
REQ-004 ipReset  in  1  asynchronous, active-low reset.
REQ-005 ipI2C_SClk  in  1  bus SCL level.
REQ-006 opI2C_SClk  out  1  SCL open-drain control, 1 = release; SHALL be held at 1 (no clock stretching).
REQ-007 ipI2C_Data  in  1  bus SDA level.
REQ-008 opI2C_Data  out  1  SDA open-drain control, 1 = release, 0 = drive low.
REQ-009 opAddress  out  8  register pointer presented to the register file.
REQ-010 opWrData  out  8  write byte.
REQ-011 opWrEnable  out  1  one-cycle write strobe.
REQ-012 opRdEnable  out  1  one-cycle read strobe.
REQ-013 ipRdData  in  8  read byte, valid the cycle after opRdEnable.
REQ-014 opBusy  out  1  high from an addressed START until the next STOP.

Function
REQ-015 SHALL pass SCL and SDA through 2-flop synchronisers, then a FilterLength glitch filter; all edge detection uses the filtered levels.
REQ-016 SHALL detect START (SDA falls while SCL high) and STOP (SDA rises while SCL high) in any state, taking precedence over bit processing in the same cycle.
REQ-017 SHALL sample SDA on each filtered SCL rising edge and change opI2C_Data within 2 cycles after each filtered SCL falling edge.
REQ-018 States: Idle, DevAddr, DevAck, Pointer, PtrAck, WrByte, WrAck, RdByte, RdAck, Ignore.
REQ-019 START -> DevAddr from any state; this includes a repeated START.
REQ-020 DevAddr: shift in 8 bits MSB first. On address match -> DevAck driving SDA low for the 9th bit. On mismatch -> Ignore, with SDA released until the next START.
REQ-021 After DevAck: R/W=0 -> Pointer. R/W=1 -> assert opRdEnable for the current opAddress, load ipRdData, -> RdByte.
REQ-022 Pointer: 8 bits load opAddress, ACK in PtrAck, then -> WrByte.
REQ-023 WrByte: 8 bits, ACK in WrAck. On the ACK falling edge, pulse opWrEnable with opWrData, then increment opAddress.
REQ-024 RdByte: shift the loaded byte out MSB first, then release SDA for RdAck. After RdAck:
- ACK (0): increment opAddress, pulse opRdEnable, reload, and continue.
- NACK (1): -> Ignore.
REQ-025 opAddress SHALL wrap 8'hFF -> 8'h00 on increment.
REQ-026 STOP -> Idle with SDA released. A partially received byte is discarded and produces no write strobe.
REQ-027 opAddress SHALL persist across transactions, so a read without a pointer byte continues from the last pointer.
REQ-028 ipClk frequency SHALL be at least 16x the SCL frequency; behaviour at lower ratios is not required.

Reset
REQ-029 While ipReset is low:
- state Idle; opAddress = 0.
- opI2C_Data = opI2C_SClk = 1.
- opWrEnable = opRdEnable = opBusy = 0.
- shift registers and filters at 1.
REQ-030 Reset mid-transfer SHALL release SDA immediately (asynchronously), with no strobes after release.

Structure
REQ-031 The state enumeration and the START/STOP/edge event encodings SHALL live in a shared I2C package, reused by the initiator drivers.
REQ-032 The synchroniser plus glitch filter SHALL be one sub-module, i2c_filter, instantiated once each for SCL and SDA.

Verification
REQ-033 Write 0x48, 0x10, 0xAB, 0xCD, STOP -> ACK on every byte; writes 0xAB@0x10 and 0xCD@0x11; opAddress = 0x12.
REQ-034 Write 0x48, 0xFF, repeated START, read 0x49, two bytes with ipRdData = reg[addr] -> bytes from 0xFF then 0x00 (wrap); master NACK on the last byte -> SDA released.
REQ-035 Address 0x50 -> NACK, SDA never driven, no strobes, opBusy = 0.
REQ-036 STOP after 4 bits of a data byte -> no opWrEnable; state Idle.
REQ-037 Single-cycle 1-sample glitch on SCL during a byte -> bit count and data unaffected.
REQ-038 ipReset asserted during the RdByte low bit -> opI2C_Data = 1 within 0 cycles; the next transaction completes normally.
